// File: rtl/clock_pkg.sv
// Encodings and display helpers shared by the clock/calendar core and its display stage.
package clock_pkg;

    localparam logic [2:0] STATUS_TIME       = 3'd0;
    localparam logic [2:0] STATUS_EDIT_HOUR  = 3'd1;
    localparam logic [2:0] STATUS_EDIT_MIN   = 3'd2;
    localparam logic [2:0] STATUS_EDIT_MONTH = 3'd3;
    localparam logic [2:0] STATUS_EDIT_DAY   = 3'd4;

    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        CONV_L,
        CONV_R
    } conv_state_e;

    // One frame's worth of display content, captured together so fields and mask stay aligned.
    typedef struct packed {
        logic [3:0] l_tens;
        logic [3:0] l_ones;
        logic [3:0] r_tens;
        logic [3:0] r_ones;
        logic [2:0] status;
        logic       sec0;
    } disp_t;

    function automatic logic [6:0] seg7_font(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    function automatic logic is_date_mode(input logic [2:0] st);
        return (st == STATUS_EDIT_MONTH) || (st == STATUS_EDIT_DAY);
    endfunction

    function automatic logic is_edit_mode(input logic [2:0] st);
        return st inside {STATUS_EDIT_HOUR, STATUS_EDIT_MIN, STATUS_EDIT_MONTH, STATUS_EDIT_DAY};
    endfunction

    function automatic logic blinks_left(input logic [2:0] st);
        return (st == STATUS_EDIT_HOUR) || (st == STATUS_EDIT_MONTH);
    endfunction

    function automatic logic blinks_right(input logic [2:0] st);
        return (st == STATUS_EDIT_MIN) || (st == STATUS_EDIT_DAY);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: load on start, then 7 iterations.
// done pulses during the final iteration; tens/ones carry the finished result while done is high.
module bin2bcd_seq
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [2:0] LAST_ITER = 3'd6;

    logic       busy_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic [7:0] bcd_q;
    logic [7:0] bcd_adj;
    logic [14:0] shifted;

    // NOTE: every variable gets a default first, so no path through the block infers a latch.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        shifted = {bcd_adj, shift_q} << 1;
    end

    // NOTE: registers use non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            shift_q <= bin;
            bcd_q   <= '0;
        end else if (busy_q) begin
            shift_q <= shifted[6:0];
            bcd_q   <= shifted[14:7];
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == LAST_ITER) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST_ITER);
    assign tens = shifted[14:11];
    assign ones = shifted[10:7];

endmodule

// File: rtl/clock_display_scan.sv
// Four-digit multiplexed 7-segment driver: HH.MM in time mode, MM.DD in date modes,
// edited field blinking; BCD conversion is done sequentially once per scan frame.
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV       = 32,
    parameter int BLINK_HALF     = 16384,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] status,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [3:0] month,
    input  logic [4:0] day,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]         digit_q, digit_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    conv_state_e        state_q, state_d;
    logic [6:0]         snap_right_q, snap_right_d;
    disp_t              pend_q, pend_d, shown_q, shown_d;
    logic [6:0]         seg_q, seg_d, seg_raw;
    logic               dp_q, dp_d, dp_raw;
    logic [3:0]         digit_en_q, digit_en_d, cur_bcd;
    logic               frame_start, blank;
    logic [6:0]         left_bin, right_bin, conv_bin;
    logic               conv_start, conv_busy, conv_done;
    logic [3:0]         conv_tens, conv_ones;
    logic               unused_second;

    assign unused_second = ^second[5:1];
    assign frame_start   = (digit_q == 2'd0) && (slot_q == '0);
    assign left_bin      = is_date_mode(status) ? {3'b000, month} : {2'b00, hour};
    assign right_bin     = is_date_mode(status) ? {2'b00, day} : {1'b0, minute};

    always_comb begin
        slot_d      = slot_q + SLOT_W'(1);
        digit_d     = digit_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = digit_q + 2'd1;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Right conversion is launched on the first CONV_R cycle, once the converter has gone idle.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_bin   = left_bin;
        case (state_q)
            CONV_L: if (conv_done) state_d = CONV_R;
            CONV_R: begin
                conv_bin = snap_right_q;
                if (!conv_busy)     conv_start = 1'b1;
                else if (conv_done) state_d    = IDLE;
            end
            default: ;
        endcase
        if (frame_start) begin
            conv_start = 1'b1;
            conv_bin   = left_bin;
            state_d    = CONV_L;
        end
    end

    always_comb begin
        shown_d      = shown_q;
        pend_d       = pend_q;
        snap_right_d = snap_right_q;
        if (frame_start) begin
            shown_d      = pend_q;
            pend_d.status = status;
            pend_d.sec0   = second[0];
            snap_right_d = right_bin;
        end
        if (conv_done && state_q == CONV_L) begin
            pend_d.l_tens = conv_tens;
            pend_d.l_ones = conv_ones;
        end
        if (conv_done && state_q == CONV_R) begin
            pend_d.r_tens = conv_tens;
            pend_d.r_ones = conv_ones;
        end
    end

    always_comb begin
        case (digit_q)
            2'd0:    cur_bcd = shown_q.l_tens;
            2'd1:    cur_bcd = shown_q.l_ones;
            2'd2:    cur_bcd = shown_q.r_tens;
            default: cur_bcd = shown_q.r_ones;
        endcase
        blank = phase_q && ((blinks_left(shown_q.status) && !digit_q[1]) ||
                            (blinks_right(shown_q.status) && digit_q[1]));
        seg_raw    = SEG_OFF;
        dp_raw     = 1'b0;
        digit_en_d = '0;
        if (slot_q != '0) begin
            digit_en_d = 4'b0001 << digit_q;
            if (!blank) begin
                seg_raw = seg7_font(cur_bcd);
                dp_raw  = (digit_q == 2'd1) && (is_edit_mode(shown_q.status) || shown_q.sec0);
            end
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_raw : dp_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            digit_q      <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            state_q      <= IDLE;
            snap_right_q <= '0;
            pend_q       <= '0;
            shown_q      <= '0;
            seg_q        <= SEG_IDLE;
            dp_q         <= SEG_ACTIVE_LOW;
            digit_en_q   <= '0;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            state_q      <= state_d;
            snap_right_q <= snap_right_d;
            pend_q       <= pend_d;
            shown_q      <= shown_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: a frame-level arithmetic model checked every cycle on two
// instances (active-high and active-low segments), plus hand-computed literal expectations.
module tb_clock_display_scan;

    localparam int SCAN_DIV   = 4;
    localparam int BLINK_HALF = 64;
    localparam int FRAME      = 4 * SCAN_DIV;
    localparam logic [6:0] FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] status;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [3:0] month;
    logic [4:0] day;
    logic [6:0] seg, seg_al;
    logic       dp, dp_al;
    logic [3:0] digit_en, digit_en_al;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int snap_st [64];
    int snap_l  [64];
    int snap_r  [64];
    bit snap_s0 [64];

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_HALF(BLINK_HALF), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .status(status), .hour(hour), .minute(minute),
        .second(second), .month(month), .day(day),
        .seg(seg), .dp(dp), .digit_en(digit_en)
    );

    clock_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_HALF(BLINK_HALF), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .status(status), .hour(hour), .minute(minute),
        .second(second), .month(month), .day(day),
        .seg(seg_al), .dp(dp_al), .digit_en(digit_en_al)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: n counts clock edges since reset release; the snapshot of each frame start is
    // what the following frame displays.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
        end else begin
            if ((n % FRAME) == 0 && (n / FRAME) < 64) begin
                snap_st[n / FRAME] <= int'(status);
                snap_l[n / FRAME]  <= (status == 3 || status == 4) ? int'(month) : int'(hour);
                snap_r[n / FRAME]  <= (status == 3 || status == 4) ? int'(day) : int'(minute);
                snap_s0[n / FRAME] <= second[0];
            end
            n <= n + 1;
        end
    end

    function automatic void model_out(input int k, output logic [6:0] s, output logic d,
                                      output logic [3:0] e);
        int c, slot, dig, f, st, l, r, val;
        bit ph, s0, blank;
        s = 7'h00;
        d = 1'b0;
        e = 4'b0000;
        if (k > 0) begin
            c    = k - 1;
            slot = c % SCAN_DIV;
            dig  = (c / SCAN_DIV) % 4;
            f    = c / FRAME;
            ph   = ((c / BLINK_HALF) % 2) == 1;
            if (f == 0 || f > 64) begin
                st = 0; l = 0; r = 0; s0 = 1'b0;
            end else begin
                st = snap_st[f-1]; l = snap_l[f-1]; r = snap_r[f-1]; s0 = snap_s0[f-1];
            end
            if (slot != 0) begin
                e = 4'(1 << dig);
                case (dig)
                    0:       val = l / 10;
                    1:       val = l % 10;
                    2:       val = r / 10;
                    default: val = r % 10;
                endcase
                blank = ph && (((st == 1 || st == 3) && dig < 2) || ((st == 2 || st == 4) && dig >= 2));
                if (!blank) begin
                    s = FONT[val];
                    d = (dig == 1) && ((st >= 1 && st <= 4) ? 1'b1 : s0);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [6:0] es;
        logic       ed;
        logic [3:0] ee;
        model_out(n, es, ed, ee);
        check($sformatf("scan n=%0d {seg,dp,en}", n), {20'd0, seg, dp, digit_en}, {20'd0, es, ed, ee});
        check($sformatf("scan_al n=%0d {seg,dp,en}", n), {20'd0, seg_al, dp_al, digit_en_al},
              {20'd0, ~es, ~ed, ee});
    end

    task automatic wait_c(input int c);
        int guard = 0;
        while (n < c + 1 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (n != c + 1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_c: reached n=%0d, required n=%0d", n, c + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        status = 3'd0; hour = 5'd23; minute = 6'd59; second = 6'd1; month = 4'd1; day = 5'd1;
        repeat (3) @(negedge clk);
        check("reset seg", seg, 7'h00);
        check("reset dp", dp, 1'b0);
        check("reset en", digit_en, 4'b0000);
        check("reset seg_al", seg_al, 7'h7F);
        check("reset dp_al", dp_al, 1'b1);
        #2 rst_n = 1'b1;

        wait_c(0);  check("first slot blank", digit_en, 4'b0000);
        wait_c(1);  check("digit0 enabled", digit_en, 4'b0001);
        check("frame0 zeros", seg, 7'h3F);

        // 23.59, second odd
        wait_c(17); check("time d0", seg, 7'h5B); check("time d0 al", seg_al, 7'h24);
        wait_c(21); check("time d1", seg, 7'h4F); check("time dp", dp, 1'b1);
        check("time en1", digit_en, 4'b0010);
        wait_c(25); check("time d2", seg, 7'h6D); check("time dp d2", dp, 1'b0);
        wait_c(29); check("time d3", seg, 7'h6F);

        // Edit month 12/31: frame 4 is in blink phase 1
        wait_c(40); status = 3'd3; month = 4'd12; day = 5'd31;
        wait_c(65); check("month blank d0", seg, 7'h00); check("month blank en", digit_en, 4'b0001);
        wait_c(69); check("month blank d1", seg, 7'h00); check("month blank dp", dp, 1'b0);
        wait_c(73); check("day d2", seg, 7'h4F);
        wait_c(77); check("day d3", seg, 7'h06);
        wait_c(129); check("month d0", seg, 7'h06);
        wait_c(133); check("month d1", seg, 7'h5B); check("date dp", dp, 1'b1);

        // Edit minute 07:05
        wait_c(136); status = 3'd2; hour = 5'd7; minute = 6'd5; second = 6'd0;
        wait_c(161); check("emin d0", seg, 7'h3F);
        wait_c(165); check("emin d1", seg, 7'h07); check("emin dp", dp, 1'b1);
        wait_c(169); check("emin d2", seg, 7'h3F);
        wait_c(173); check("emin d3", seg, 7'h6D);
        wait_c(193); check("emin ph1 d0", seg, 7'h3F);
        wait_c(197); check("emin ph1 d1", seg, 7'h07); check("emin ph1 dp", dp, 1'b1);
        wait_c(201); check("emin ph1 d2", seg, 7'h00); check("emin ph1 en2", digit_en, 4'b0100);
        wait_c(205); check("emin ph1 d3", seg, 7'h00);

        // Status 6 behaves as time mode, no blink in phase 1
        wait_c(210); status = 3'd6; hour = 5'd23; minute = 6'd59;
        wait_c(241); check("st6 d0", seg, 7'h5B);
        wait_c(245); check("st6 d1", seg, 7'h4F); check("st6 dp", dp, 1'b0);
        wait_c(253); check("st6 d3", seg, 7'h6F);

        // Mid-frame minute change: old value one more frame, new from the second frame start
        second = 6'd1;
        wait_c(262); minute = 6'd0;
        wait_c(285); check("old minute d3", seg, 7'h6F);
        wait_c(297); check("new minute d2", seg, 7'h3F);
        wait_c(301); check("new minute d3", seg, 7'h3F);

        // Reset during right-field conversion
        wait_c(314);
        #2 rst_n = 1'b0;
        #1;
        check("midreset seg", seg, 7'h00);
        check("midreset en", digit_en, 4'b0000);
        check("midreset seg_al", seg_al, 7'h7F);
        status = 3'd0; hour = 5'd12; minute = 6'd34; second = 6'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_c(1);  check("post-reset zeros", seg, 7'h3F);
        wait_c(17); check("fresh d0", seg, 7'h06);
        wait_c(21); check("fresh d1", seg, 7'h5B); check("fresh dp", dp, 1'b0);
        wait_c(25); check("fresh d2", seg, 7'h4F);
        wait_c(29); check("fresh d3", seg, 7'h66);
        wait_c(36);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
